// File: rtl/mult3b_seq.sv
// Sequential 3x3 unsigned multiplier: shift-and-add over three CALC steps,
// built around the soma3b ripple adder, with a start/busy/done handshake.

module soma3b (
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [3:0] s
);
  logic [3:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 3; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign s[3] = c[3];
endmodule

module mult3b_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] a,
  input  logic [2:0] b,
  output logic [5:0] product,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] m;
  logic [3:0] acc;
  logic [2:0] q;
  logic [1:0] cnt;

  logic [3:0] add_sum;
  logic [3:0] step_sum;
  logic [3:0] acc_next;
  logic [2:0] q_next;
  logic       carry_unused;

  soma3b u_add (
    .x (acc[2:0]),
    .y (m),
    .s (add_sum)
  );

  assign step_sum = q[0] ? add_sum : {1'b0, acc[2:0]};
  assign acc_next = {1'b0, step_sum[3:1]};
  assign q_next   = {step_sum[0], q[2:1]};

  // The right shift always clears acc[3], so it never feeds the next step.
  assign carry_unused = acc[3];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == 2'd2) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a;
            q   <= b;
            acc <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          acc <= acc_next;
          q   <= q_next;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd2) product <= {acc_next[2:0], q_next};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
endmodule
